// File: rtl/com_config_shift_ctrl.sv
// Serial shift-out of one of three 256x16 configuration arrays to the ASIC scan port.
// Bits leave word 0 first, MSB first; a LOAD strobe follows the last bit.
module com_config_shift_ctrl (
    input  logic                  fw_clk_100,
    input  logic                  fw_rst_n,
    input  logic                  op_code_w_reset,
    input  logic                  start,
    input  logic [1:0]            sel_array,
    input  logic [7:0]            clk_div,
    input  logic [255:0][15:0]    cfg_array_0,
    input  logic [255:0][15:0]    cfg_array_1,
    input  logic [255:0][15:0]    cfg_array_2,
    output logic                  scan_clk,
    output logic                  scan_din,
    output logic                  scan_load,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_LOAD,
        ST_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] bit_q, bit_d;
    logic [9:0]  half_q, half_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  div_q, div_d;
    logic        scan_clk_q, scan_clk_d;
    logic        scan_din_q, scan_din_d;
    logic        scan_load_q, scan_load_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic [9:0]  half_end;
    logic [9:0]  load_hi_lim;
    logic [9:0]  load_end;

    // Arrays are read live; the caller guarantees they are stable while busy.
    function automatic logic fetch_bit(input logic [1:0] sel, input logic [11:0] n);
        logic [7:0] w;
        logic [3:0] b;
        w = n[11:4];
        b = 4'd15 - n[3:0];
        case (sel)
            2'd0:    fetch_bit = cfg_array_0[w][b];
            2'd1:    fetch_bit = cfg_array_1[w][b];
            2'd2:    fetch_bit = cfg_array_2[w][b];
            default: fetch_bit = 1'b0;
        endcase
    endfunction

    assign half_end    = {2'b00, div_q};
    assign load_hi_lim = {1'b0, div_q, 1'b0} + 10'd1;
    // LOAD holds the strobe for 2*(div+1) cycles plus one trailing busy cycle.
    assign load_end    = {1'b0, div_q, 1'b0} + 10'd2;

    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        half_d      = half_q;
        sel_d       = sel_q;
        div_d       = div_q;
        scan_clk_d  = scan_clk_q;
        scan_din_d  = scan_din_q;
        scan_load_d = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d     = 1'b0;
                scan_clk_d = 1'b0;
                if (start) begin
                    if (sel_array != 2'd3) begin
                        sel_d      = sel_array;
                        div_d      = clk_div;
                        bit_d      = '0;
                        half_d     = '0;
                        state_d    = ST_LOW;
                        busy_d     = 1'b1;
                        scan_din_d = fetch_bit(sel_array, 12'd0);
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (half_q == half_end) begin
                    half_d     = '0;
                    state_d    = ST_HIGH;
                    scan_clk_d = 1'b1;
                end else begin
                    half_d = half_q + 10'd1;
                end
            end
            ST_HIGH: begin
                if (half_q == half_end) begin
                    half_d     = '0;
                    scan_clk_d = 1'b0;
                    if (bit_q == 12'd4095) begin
                        state_d     = ST_LOAD;
                        scan_load_d = 1'b1;
                        scan_din_d  = 1'b0;
                    end else begin
                        bit_d      = bit_q + 12'd1;
                        state_d    = ST_LOW;
                        scan_din_d = fetch_bit(sel_q, bit_q + 12'd1);
                    end
                end else begin
                    half_d = half_q + 10'd1;
                end
            end
            ST_LOAD: begin
                if (half_q == load_end) begin
                    half_d  = '0;
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    half_d      = half_q + 10'd1;
                    scan_load_d = (half_q < load_hi_lim);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (op_code_w_reset) begin
            state_d     = ST_IDLE;
            bit_d       = '0;
            half_d      = '0;
            scan_clk_d  = 1'b0;
            scan_din_d  = 1'b0;
            scan_load_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            error_d     = 1'b0;
        end
    end

    always_ff @(posedge fw_clk_100 or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            state_q     <= ST_IDLE;
            bit_q       <= '0;
            half_q      <= '0;
            sel_q       <= '0;
            div_q       <= '0;
            scan_clk_q  <= 1'b0;
            scan_din_q  <= 1'b0;
            scan_load_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            half_q      <= half_d;
            sel_q       <= sel_d;
            div_q       <= div_d;
            scan_clk_q  <= scan_clk_d;
            scan_din_q  <= scan_din_d;
            scan_load_q <= scan_load_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign scan_clk  = scan_clk_q;
    assign scan_din  = scan_din_q;
    assign scan_load = scan_load_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
